rename_multi: RTL and testbench
===============================

# rename_multi

Multi-issue register rename table for the out-of-order core, the parametrised successor of the single-lane `rename` block. Sits between decode and dispatch. Each cycle it renames up to `DEC_WIDTH` instructions in program order, with intra-group dependency bypass. Its architectural-register-to-ROB-ID map is updated by up to `COM_WIDTH` commits per cycle and cleared wholesale on `flush`.

## Interface
- `ROB_DEPTH`, default `` `RobDepth ``: ROB entries.
- `ROB`, default `$clog2(ROB_DEPTH)`: ROB ID width.
- `DEC_WIDTH`, default 2: decode/rename lanes; lane 0 is oldest.
- `COM_WIDTH`, default 2: commit lanes.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dec_e_`  in  DEC_WIDTH  per-lane valid, active-low.
- `dec_invalid`  in  DEC_WIDTH  lane carries an invalid/exception instruction; no table write.
- `dec_rd`, `dec_rs1`, `dec_rs2`  in  RegFile_t[DEC_WIDTH]  architectural operands.
- `dec_rob_id`  in  ROB[DEC_WIDTH]  ROB entry allocated to each lane.
- `commit_e_`  in  COM_WIDTH  per-lane commit valid, active-low.
- `com_rob_id`  in  ROB[COM_WIDTH]  committing ROB IDs.
- `flush`  in  1  pipeline flush; clears the whole map.
- `ren_e_`  out  DEC_WIDTH  registered lane valid, active-low.
- `ren_rs1_busy`, `ren_rs2_busy`  out  DEC_WIDTH  operand is produced by an in-flight instruction.
- `ren_rs1_rob`, `ren_rs2_rob`  out  ROB[DEC_WIDTH]  producer ROB ID; 0 when not busy.
- `ren_rd`  out  RegFile_t[DEC_WIDTH]  registered copy of `dec_rd`.
- `ren_rob_id`  out  ROB[DEC_WIDTH]  registered copy of `dec_rob_id`.

## Operation
- Map: per architectural register, one `busy` bit and one `ROB`-bit producer tag. GPR x0 is never marked busy.
- **Lookup, lane i:**
  - The source is busy with producer tag T if a lane j<i in the same group is enabled, valid and has `dec_rd == src`. The youngest such j supplies T.
  - Otherwise the map entry is used.
  - If the map entry is busy and its tag equals any `com_rob_id` committing this cycle, the source is reported not busy (commit bypass).
- **Allocate:** an enabled lane with `!dec_invalid` and `dec_rd` not x0 sets `busy=1` and `tag=dec_rob_id`. If several lanes write the same rd, the highest lane wins.
- **Commit:** for each committing ID, any entry with `busy && tag==com_rob_id` is cleared. An entry whose tag was overwritten by a younger writer is left untouched.
- **Same cycle, same register, allocate and commit:** the allocate wins.
- **`flush`:**
  - All busy bits clear at the next edge.
  - Decode lanes in the flush cycle are ignored: `ren_e_` is all `Disable_` next cycle.
  - Commits in the flush cycle are irrelevant.
- **`reset`:** clears all busy and tag bits. All outputs go to `ren_e_` all `Disable_`, busy 0, rob 0, `ren_rd` 0, `ren_rob_id` 0.
- `dec_invalid` lanes still propagate to `ren_e_` with `ren_rd` passed through, so the ROB can record the exception.

## Timing
- Lookup and allocate occupy one stage. Outputs are registered: 1-cycle latency from `dec_*` to `ren_*`.
- No backpressure; the upstream stalls by deasserting `dec_e_`.
- An allocate in cycle N is visible to map lookups from cycle N+1. Same-cycle visibility is through the intra-group bypass only.
- A commit in cycle N affects lookups in cycle N via the bypass, and the map from cycle N+1.
- `reset` has priority over `flush`, and `flush` over decode/commit.
- ROB ID wrap-around is handled by the ROB. Tags are compared for equality only.

## Configuration
- `RENAME_FPR_EN`
  - Defined: a second map bank tracks FPRs, indexed by `regtype == TYPE_FPR`, and all FPR registers including f0 are renamable.
  - Undefined: only GPR operands are renamed; non-GPR operands always report busy 0 and are never allocated.

## Structure
- Shared package (`regfile.svh` / `cpu_config.svh`):
  - `RegFile_t`, `TYPE_GPR`, `TYPE_FPR`, `` `RobDepth ``.
  - A new `RenEntry_t` struct {busy, tag}.
- Sub-module `rename_bypass`: combinational per-lane source resolution. Performs the intra-group priority search and the commit-bypass compare. It is instantiated twice per lane, once for rs1 and once for rs2.
- Map storage, allocate/commit/flush update and output registers live in `rename_multi`.

## Test plan
- Lane0 rd=x1 rob=4, then next cycle lane0 rs1=x1 rs2=x2 -> busy1=1 rob1=4, busy2=0 rob2=0.
- Same group: lane0 rd=x3 rob=6, lane1 rs1=x3 -> lane1 busy1=1 rob1=6 (intra-group bypass).
- x1→rob4, then x1→rob5, then commit rob4 -> lookup x1 still busy rob=5; then commit rob5 -> x1 not busy.
- Lane0 and lane1 both write rd=x7 with rob 8 and 9 -> later lookup of x7 gives rob=9.
- Lookup x1 (mapped rob4) in the same cycle as commit rob4 -> busy1=0. Lookup of rd=x0 with rob=3 -> x0 never busy.
- Map x1–x5, pulse `flush` with lane0 enabled -> `ren_e_` all `Disable_` next cycle, all lookups busy 0. Assert `reset` mid-stream -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/rename_multi_pkg.sv
// Shared types for the multi-issue rename table: register operand encoding,
// map entry layout and active-low enable levels.
`ifndef RobDepth
`define RobDepth 16
`endif

package rename_multi_pkg;

  typedef enum logic {
    TYPE_GPR = 1'b0,
    TYPE_FPR = 1'b1
  } regtype_t;

  typedef struct packed {
    regtype_t   regtype;
    logic [4:0] num;
  } RegFile_t;

  localparam int REN_TAG_W = $clog2(`RobDepth);

  typedef struct packed {
    logic                 busy;
    logic [REN_TAG_W-1:0] tag;
  } RenEntry_t;

  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

endpackage

// File: rtl/rename_bypass.sv
// Per-lane source resolution: youngest older lane in the group writing the
// source wins, otherwise the map entry, masked by a same-cycle commit.
module rename_bypass
  import rename_multi_pkg::*;
#(
  parameter int DEC_WIDTH = 2,
  parameter int COM_WIDTH = 2,
  parameter int ROB       = 4,
  parameter int LANE      = 0
) (
  input  RegFile_t             src,
  input  logic                 src_ok,
  input  RenEntry_t            entry,
  input  logic [DEC_WIDTH-1:0] dec_e_,
  input  logic [DEC_WIDTH-1:0] dec_invalid,
  input  RegFile_t             dec_rd     [DEC_WIDTH],
  input  logic [ROB-1:0]       dec_rob_id [DEC_WIDTH],
  input  logic [COM_WIDTH-1:0] commit_e_,
  input  logic [ROB-1:0]       com_rob_id [COM_WIDTH],
  output logic                 busy,
  output logic [ROB-1:0]       rob
);

  logic           grp_hit;
  logic [ROB-1:0] grp_tag;
  logic           com_hit;

  always_comb begin
    grp_hit = 1'b0;
    grp_tag = '0;
    // ascending scan so the youngest matching older lane is the last to write
    for (int j = 0; j < DEC_WIDTH; j++) begin
      if (j < LANE && dec_e_[j] == Enable_ && !dec_invalid[j] && dec_rd[j] == src) begin
        grp_hit = 1'b1;
        grp_tag = dec_rob_id[j];
      end
    end
    com_hit = 1'b0;
    for (int k = 0; k < COM_WIDTH; k++) begin
      if (commit_e_[k] == Enable_ && com_rob_id[k] == ROB'(entry.tag)) com_hit = 1'b1;
    end
  end

  always_comb begin
    busy = 1'b0;
    rob  = '0;
    if (src_ok) begin
      if (grp_hit) begin
        busy = 1'b1;
        rob  = grp_tag;
      end else if (entry.busy && !com_hit) begin
        busy = 1'b1;
        rob  = ROB'(entry.tag);
      end
    end
  end

endmodule

// File: rtl/rename_multi.sv
// Multi-issue register rename table: arch-reg -> ROB-ID map with commit and
// flush clearing. Define RENAME_FPR_EN to add a second bank renaming FPRs.
`ifndef RobDepth
`define RobDepth 16
`endif

module rename_multi
  import rename_multi_pkg::*;
#(
  parameter int ROB_DEPTH = `RobDepth,
  parameter int ROB       = $clog2(ROB_DEPTH),
  parameter int DEC_WIDTH = 2,
  parameter int COM_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DEC_WIDTH-1:0] dec_e_,
  input  logic [DEC_WIDTH-1:0] dec_invalid,
  input  RegFile_t             dec_rd       [DEC_WIDTH],
  input  RegFile_t             dec_rs1      [DEC_WIDTH],
  input  RegFile_t             dec_rs2      [DEC_WIDTH],
  input  logic [ROB-1:0]       dec_rob_id   [DEC_WIDTH],
  input  logic [COM_WIDTH-1:0] commit_e_,
  input  logic [ROB-1:0]       com_rob_id   [COM_WIDTH],
  input  logic                 flush,
  output logic [DEC_WIDTH-1:0] ren_e_,
  output logic [DEC_WIDTH-1:0] ren_rs1_busy,
  output logic [DEC_WIDTH-1:0] ren_rs2_busy,
  output logic [ROB-1:0]       ren_rs1_rob  [DEC_WIDTH],
  output logic [ROB-1:0]       ren_rs2_rob  [DEC_WIDTH],
  output RegFile_t             ren_rd       [DEC_WIDTH],
  output logic [ROB-1:0]       ren_rob_id   [DEC_WIDTH]
);

`ifdef RENAME_FPR_EN
  localparam int MAP_ENTRIES = 64;
`else
  localparam int MAP_ENTRIES = 32;
`endif
  localparam int IDX_W = $clog2(MAP_ENTRIES);

  function automatic logic [IDX_W-1:0] map_idx(input RegFile_t r);
`ifdef RENAME_FPR_EN
    return {r.regtype == TYPE_FPR, r.num};
`else
    return r.num;
`endif
  endfunction

  function automatic logic renamable(input RegFile_t r);
`ifdef RENAME_FPR_EN
    return (r.regtype == TYPE_FPR) || (r.num != 5'd0);
`else
    return (r.regtype == TYPE_GPR) && (r.num != 5'd0);
`endif
  endfunction

  RenEntry_t            map_q [MAP_ENTRIES];
  RenEntry_t            map_d [MAP_ENTRIES];
  logic [DEC_WIDTH-1:0] alloc;
  logic [DEC_WIDTH-1:0] rs1_busy, rs2_busy;
  logic [ROB-1:0]       rs1_rob [DEC_WIDTH];
  logic [ROB-1:0]       rs2_rob [DEC_WIDTH];

  always_comb begin
    for (int i = 0; i < DEC_WIDTH; i++)
      alloc[i] = (dec_e_[i] == Enable_) && !dec_invalid[i] && renamable(dec_rd[i]);
  end

  // commits clear first so a same-cycle allocate to the same register wins
  always_comb begin
    map_d = map_q;
    for (int e = 0; e < MAP_ENTRIES; e++) begin
      for (int k = 0; k < COM_WIDTH; k++) begin
        if (commit_e_[k] == Enable_ && map_q[e].busy && ROB'(map_q[e].tag) == com_rob_id[k])
          map_d[e].busy = 1'b0;
      end
    end
    for (int i = 0; i < DEC_WIDTH; i++) begin
      if (alloc[i]) map_d[map_idx(dec_rd[i])] = '{busy: 1'b1, tag: REN_TAG_W'(dec_rob_id[i])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int e = 0; e < MAP_ENTRIES; e++) map_q[e] <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  for (genvar g = 0; g < DEC_WIDTH; g++) begin : g_lane
    rename_bypass #(
      .DEC_WIDTH(DEC_WIDTH), .COM_WIDTH(COM_WIDTH), .ROB(ROB), .LANE(g)
    ) u_rs1 (
      .src(dec_rs1[g]), .src_ok(renamable(dec_rs1[g])), .entry(map_q[map_idx(dec_rs1[g])]),
      .dec_e_(dec_e_), .dec_invalid(dec_invalid), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
      .commit_e_(commit_e_), .com_rob_id(com_rob_id),
      .busy(rs1_busy[g]), .rob(rs1_rob[g])
    );
    rename_bypass #(
      .DEC_WIDTH(DEC_WIDTH), .COM_WIDTH(COM_WIDTH), .ROB(ROB), .LANE(g)
    ) u_rs2 (
      .src(dec_rs2[g]), .src_ok(renamable(dec_rs2[g])), .entry(map_q[map_idx(dec_rs2[g])]),
      .dec_e_(dec_e_), .dec_invalid(dec_invalid), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
      .commit_e_(commit_e_), .com_rob_id(com_rob_id),
      .busy(rs2_busy[g]), .rob(rs2_rob[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ren_e_       <= {DEC_WIDTH{Disable_}};
      ren_rs1_busy <= '0;
      ren_rs2_busy <= '0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
        ren_rs1_rob[i] <= '0;
        ren_rs2_rob[i] <= '0;
        ren_rd[i]      <= '0;
        ren_rob_id[i]  <= '0;
      end
    end else begin
      ren_e_       <= flush ? {DEC_WIDTH{Disable_}} : dec_e_;
      ren_rs1_busy <= flush ? '0 : rs1_busy;
      ren_rs2_busy <= flush ? '0 : rs2_busy;
      for (int i = 0; i < DEC_WIDTH; i++) begin
        ren_rs1_rob[i] <= flush ? '0 : rs1_rob[i];
        ren_rs2_rob[i] <= flush ? '0 : rs2_rob[i];
        ren_rd[i]      <= dec_rd[i];
        ren_rob_id[i]  <= dec_rob_id[i];
      end
    end
  end

endmodule

// File: tb/tb_rename_multi.sv
// Bench for rename_multi: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a register-map model.
`ifndef RobDepth
`define RobDepth 16
`endif

module tb_rename_multi;
  import rename_multi_pkg::*;

  localparam int DW   = 2;
  localparam int CW   = 2;
  localparam int ROB  = $clog2(`RobDepth);
  localparam int NREG = 64;

  logic           clk = 1'b0;
  logic           reset, flush;
  logic [DW-1:0]  dec_e_, dec_invalid;
  RegFile_t       dec_rd [DW], dec_rs1 [DW], dec_rs2 [DW];
  logic [ROB-1:0] dec_rob_id [DW];
  logic [CW-1:0]  commit_e_;
  logic [ROB-1:0] com_rob_id [CW];
  logic [DW-1:0]  ren_e_, ren_rs1_busy, ren_rs2_busy;
  logic [ROB-1:0] ren_rs1_rob [DW], ren_rs2_rob [DW], ren_rob_id [DW];
  RegFile_t       ren_rd [DW];

  rename_multi #(.DEC_WIDTH(DW), .COM_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .dec_e_(dec_e_), .dec_invalid(dec_invalid),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rob_id(dec_rob_id),
    .commit_e_(commit_e_), .com_rob_id(com_rob_id), .flush(flush),
    .ren_e_(ren_e_), .ren_rs1_busy(ren_rs1_busy), .ren_rs2_busy(ren_rs2_busy),
    .ren_rs1_rob(ren_rs1_rob), .ren_rs2_rob(ren_rs2_rob), .ren_rd(ren_rd),
    .ren_rob_id(ren_rob_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int lane, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0d expected %0d", name, lane, act, exp);
    end
  endtask

  // register operands as integers: 0..31 = x0..x31, 32..63 = f0..f31
  function automatic int code(input RegFile_t r);
    return (r.regtype == TYPE_FPR ? 32 : 0) + int'(r.num);
  endfunction

  function automatic RegFile_t to_reg(input int c);
    RegFile_t r;
    r.regtype = (c >= 32) ? TYPE_FPR : TYPE_GPR;
    r.num     = 5'(c % 32);
    return r;
  endfunction

  function automatic bit m_renamable(input int c);
`ifdef RENAME_FPR_EN
    return c != 0;
`else
    return c != 0 && c < 32;
`endif
  endfunction

  // model: per register "who will produce it", or nobody
  bit m_busy [NREG];
  int m_tag  [NREG];
  bit exp_valid = 1'b0;
  bit exp_rst;
  int exp_e [DW], exp_rd [DW], exp_rid [DW];
  int exp_b1 [DW], exp_r1 [DW], exp_b2 [DW], exp_r2 [DW];

  function automatic bit committing(input int id);
    for (int k = 0; k < CW; k++)
      if (commit_e_[k] == Enable_ && int'(com_rob_id[k]) == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_lookup(input int lane, input int src, output int b, output int t);
    b = 0;
    t = 0;
    if (!m_renamable(src)) return;
    for (int j = lane - 1; j >= 0; j--) begin
      if (dec_e_[j] == Enable_ && !dec_invalid[j] && code(dec_rd[j]) == src) begin
        b = 1;
        t = int'(dec_rob_id[j]);
        return;
      end
    end
    if (m_busy[src] && !committing(m_tag[src])) begin
      b = 1;
      t = m_tag[src];
    end
  endtask

  initial forever begin
    @(posedge clk);
    exp_valid = 1'b1;
    if (reset || flush) begin
      exp_rst = reset;
      for (int r = 0; r < NREG; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
      for (int i = 0; i < DW; i++) exp_e[i] = 1;
    end else begin
      bit done [NREG];
      exp_rst = 1'b0;
      for (int i = 0; i < DW; i++) begin
        exp_e[i]   = int'(dec_e_[i]);
        exp_rd[i]  = code(dec_rd[i]);
        exp_rid[i] = int'(dec_rob_id[i]);
        m_lookup(i, code(dec_rs1[i]), exp_b1[i], exp_r1[i]);
        m_lookup(i, code(dec_rs2[i]), exp_b2[i], exp_r2[i]);
      end
      for (int r = 0; r < NREG; r++) done[r] = m_busy[r] && committing(m_tag[r]);
      for (int r = 0; r < NREG; r++) if (done[r]) m_busy[r] = 0;
      for (int i = 0; i < DW; i++) begin
        if (dec_e_[i] == Enable_ && !dec_invalid[i] && m_renamable(code(dec_rd[i]))) begin
          m_busy[code(dec_rd[i])] = 1;
          m_tag[code(dec_rd[i])]  = int'(dec_rob_id[i]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_valid) begin
      for (int i = 0; i < DW; i++) begin
        chk("ren_e_", i, int'(ren_e_[i]), exp_e[i]);
        if (exp_rst) begin
          chk("rst_rs1_busy", i, int'(ren_rs1_busy[i]), 0);
          chk("rst_rs2_busy", i, int'(ren_rs2_busy[i]), 0);
          chk("rst_rs1_rob", i, int'(ren_rs1_rob[i]), 0);
          chk("rst_rs2_rob", i, int'(ren_rs2_rob[i]), 0);
          chk("rst_rd", i, code(ren_rd[i]), 0);
          chk("rst_rob_id", i, int'(ren_rob_id[i]), 0);
        end else if (exp_e[i] == 0) begin
          chk("ren_rd", i, code(ren_rd[i]), exp_rd[i]);
          chk("ren_rob_id", i, int'(ren_rob_id[i]), exp_rid[i]);
          chk("rs1_busy", i, int'(ren_rs1_busy[i]), exp_b1[i]);
          chk("rs1_rob", i, int'(ren_rs1_rob[i]), exp_r1[i]);
          chk("rs2_busy", i, int'(ren_rs2_busy[i]), exp_b2[i]);
          chk("rs2_rob", i, int'(ren_rs2_rob[i]), exp_r2[i]);
        end
      end
    end
  end

  task automatic idle();
    reset = 1'b0;
    flush = 1'b0;
    dec_e_ = '1;
    dec_invalid = '0;
    commit_e_ = '1;
    for (int i = 0; i < DW; i++) begin
      dec_rd[i] = '0; dec_rs1[i] = '0; dec_rs2[i] = '0; dec_rob_id[i] = '0;
    end
    for (int k = 0; k < CW; k++) com_rob_id[k] = '0;
  endtask

  task automatic lane(input int l, input int rd, input int rs1, input int rs2, input int rob);
    dec_e_[l]     = Enable_;
    dec_rd[l]     = to_reg(rd);
    dec_rs1[l]    = to_reg(rs1);
    dec_rs2[l]    = to_reg(rs2);
    dec_rob_id[l] = ROB'(rob);
  endtask

  task automatic commit(input int k, input int id);
    commit_e_[k]  = Enable_;
    com_rob_id[k] = ROB'(id);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    chk("reset_e", 0, int'(ren_e_), 3);

    idle(); lane(0, 1, 0, 0, 4); tick();
    idle(); lane(0, 0, 1, 2, 0); tick();
    chk("dir_x1_busy", 0, int'(ren_rs1_busy[0]), 1);
    chk("dir_x1_rob", 0, int'(ren_rs1_rob[0]), 4);
    chk("dir_x2_busy", 0, int'(ren_rs2_busy[0]), 0);
    chk("dir_x2_rob", 0, int'(ren_rs2_rob[0]), 0);

    idle(); lane(0, 3, 0, 0, 6); lane(1, 0, 3, 0, 7); tick();
    chk("grp_bypass_busy", 1, int'(ren_rs1_busy[1]), 1);
    chk("grp_bypass_rob", 1, int'(ren_rs1_rob[1]), 6);

    idle(); lane(0, 1, 0, 0, 5); tick();
    idle(); commit(0, 4); tick();
    idle(); lane(0, 0, 1, 0, 0); tick();
    chk("stale_commit_busy", 0, int'(ren_rs1_busy[0]), 1);
    chk("stale_commit_rob", 0, int'(ren_rs1_rob[0]), 5);
    idle(); commit(0, 5); tick();
    idle(); lane(0, 0, 1, 0, 0); tick();
    chk("committed_busy", 0, int'(ren_rs1_busy[0]), 0);

    idle(); lane(0, 7, 0, 0, 8); lane(1, 7, 0, 0, 9); tick();
    idle(); lane(0, 0, 7, 0, 0); tick();
    chk("waw_rob", 0, int'(ren_rs1_rob[0]), 9);

    idle(); lane(0, 2, 0, 0, 4); tick();
    idle(); lane(0, 0, 2, 0, 0); lane(1, 0, 0, 3, 0); commit(1, 4); tick();
    chk("com_bypass_busy", 0, int'(ren_rs1_busy[0]), 0);
    chk("other_reg_busy", 1, int'(ren_rs2_busy[1]), 1);
    chk("other_reg_rob", 1, int'(ren_rs2_rob[1]), 6);

    idle(); lane(0, 0, 0, 0, 3); lane(1, 0, 0, 0, 1); tick();
    idle(); lane(0, 0, 0, 0, 0); tick();
    chk("x0_busy", 0, int'(ren_rs1_busy[0]), 0);

    idle(); lane(0, 1, 0, 0, 1); lane(1, 2, 0, 0, 2); tick();
    idle(); lane(0, 3, 0, 0, 3); lane(1, 4, 0, 0, 4); tick();
    idle(); lane(0, 5, 0, 0, 5); tick();
    idle(); flush = 1'b1; lane(0, 0, 1, 0, 0); tick();
    chk("flush_e", 0, int'(ren_e_), 3);
    idle(); lane(0, 0, 1, 2, 0); lane(1, 0, 3, 5, 0); tick();
    chk("post_flush_busy", 0, int'({ren_rs1_busy, ren_rs2_busy}), 0);

    idle(); lane(0, 6, 0, 0, 10); tick();
    idle(); reset = 1'b1; lane(0, 0, 6, 0, 2); lane(1, 1, 0, 0, 3); tick();
    chk("mid_reset_e", 0, int'(ren_e_), 3);
    chk("mid_reset_rob_id", 1, int'(ren_rob_id[1]), 0);
    idle(); lane(0, 0, 6, 0, 0); tick();
    chk("post_reset_busy", 0, int'(ren_rs1_busy[0]), 0);

    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(199) == 0);
      flush = ($urandom_range(24) == 0);
      for (int i = 0; i < DW; i++) begin
        int regs [3];
        for (int s = 0; s < 3; s++)
          regs[s] = ($urandom_range(9) < 8) ? $urandom_range(7) : 32 + $urandom_range(3);
        dec_e_[i]      = $urandom_range(3) != 0 ? Enable_ : Disable_;
        dec_invalid[i] = $urandom_range(7) == 0;
        dec_rd[i]      = to_reg(regs[0]);
        dec_rs1[i]     = to_reg(regs[1]);
        dec_rs2[i]     = to_reg(regs[2]);
        dec_rob_id[i]  = ROB'($urandom_range(`RobDepth - 1));
      end
      for (int k = 0; k < CW; k++) begin
        if ($urandom_range(1) == 0)
          commit(k, ($urandom_range(4) < 3) ? m_tag[$urandom_range(7)] : $urandom_range(`RobDepth - 1));
      end
      tick();
    end

    idle();
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
